multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle variant of the RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared datapath resources: a single memory, one ALU and the immediate sign extender.
- Decodes op/funct fields and emits per-state control strobes, including ImmSrc to the sign extender.
- Sits beside the datapath; all outputs are decoded from the registered state plus instruction fields.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction[6:0] from the instruction register
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- PCWrite  output  1  PC register enable (includes branch-taken term)
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file write enable
- illegal  output  1  sticky flag: unsupported opcode decoded
- state  output  4  current state, for debug and verification

Behaviour:
- States (codes 0–10): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Reset: on any clk edge with reset = 1, state <= RESET_STATE and illegal <= 0. Reset overrides everything, including mid-instruction and mid-stall.
- While state = FETCH (including the cycle after reset), all strobes are 0 except FETCH's own strobes.
- Transitions:
  - FETCH -> DECODE when mem_ready, else stay.
  - DECODE -> MEMADR (op 0000011 / 0100011), EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111).
  - DECODE with any other op: go to FETCH and set illegal.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB when mem_ready, else stay.
  - MEMWRITE -> FETCH when mem_ready, else stay.
  - MEMWB, BEQ -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB.
  - ALUWB -> FETCH.
- Strobes per state (unlisted strobes are 0):
  - FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp add, ResultSrc = 10. IRWrite = PCWrite = mem_ready.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp add. Precomputes the branch target.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp add.
  - MEMREAD: AdrSrc = 1, ResultSrc = 00.
  - MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 for every cycle held.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp funct.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp funct.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp sub, ResultSrc = 00, PCWrite = zero.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp add, ResultSrc = 00, PCWrite = 1.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp funct, by funct3:
    - 000: sub (001) only when EXECR and funct7b5 = 1; otherwise add. I-type never subtracts.
    - 010 -> 101; 110 -> 011; 111 -> 010.
    - Any other funct3 -> 000, and sets illegal.
- ImmSrc: combinational from op in every state.
  - I (0000011, 0010011) -> 00; S (0100011) -> 01; B (1100011) -> 10; J (1101111) -> 11.
  - All other op values -> 00.
- With MEM_WAIT_EN = 1, a mem_ready-gated state holds until mem_ready. Holds are unbounded, with no timeout.
- illegal clears only on reset.
- Latency with mem_ready = 1: beq 3 cycles; R, I, jal, sw 4; lw 5.

Test Plan:
- Reset then add (op 0110011, funct3 000, funct7b5 0), mem_ready = 1 -> states 0,1,6,8,0. RegWrite = 1 only in ALUWB. ALUControl = 000 in EXECR.
- lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles. RegWrite asserts once, in MEMWB. ImmSrc = 00 throughout.
- sw, then beq with zero = 1, then beq with zero = 0:
  - sw: ImmSrc = 01; MemWrite high only in MEMWRITE.
  - beq, zero = 1: ImmSrc = 10; PCWrite = 1 in BEQ.
  - beq, zero = 0: PCWrite = 0 in BEQ.
- jal -> ImmSrc = 11. PCWrite = 1 in JAL; RegWrite = 1 in the following ALUWB.
- Op 1111111 in DECODE -> next state FETCH, illegal = 1 and stays 1. A later reset clears it.
- Reset asserted while in MEMREAD with mem_ready = 0 -> state = 0 next cycle. MemWrite = RegWrite = 0 in that cycle.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, status and control strobes between controller and datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;
  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal, state
  );
  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing the shared datapath of a multi-cycle RV32I core
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  state_t s;
  logic [1:0] alu_op;
  logic rdy, bad_f3;
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  assign bad_f3 = !(bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  assign bus.state = s;
  assign bus.ImmSrc = (bus.op == OP_SW) ? 2'b01 : (bus.op == OP_BEQ) ? 2'b10 :
                      (bus.op == OP_JAL) ? 2'b11 : 2'b00;
  // Next-state sequencing and sticky illegal flag; unused codes fall back to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= state_t'(RESET_STATE);
      bus.illegal <= 1'b0;
    end else begin
      case (s)
        FETCH: if (rdy) s <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: s <= MEMADR;
            OP_R: s <= EXECR;
            OP_I: s <= EXECI;
            OP_BEQ: s <= BEQ;
            OP_JAL: s <= JAL;
            default: begin
              s <= FETCH;
              bus.illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: s <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD: if (rdy) s <= MEMWB;
        MEMWRITE: if (rdy) s <= FETCH;
        EXECR, EXECI: begin
          s <= ALUWB;
          if (bad_f3) bus.illegal <= 1'b1;
        end
        JAL: s <= ALUWB;
        default: s <= FETCH;
      endcase
    end
  end
  // Per-state strobes; alu_op 00 add, 01 sub, 10 decode from funct fields
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.RegWrite = 1'b0;
    alu_op = 2'b00;
    case (s)
      FETCH: begin
        bus.PCWrite = rdy;
        bus.IRWrite = rdy;
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite = 1'b1;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        alu_op = 2'b10;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op = 2'b10;
      end
      ALUWB: bus.RegWrite = 1'b1;
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        alu_op = 2'b01;
        bus.PCWrite = bus.zero;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
    bus.ALUControl = (alu_op == 2'b00) ? 3'b000 :
                     (alu_op == 2'b01) ? 3'b001 :
                     (bus.funct3 == 3'b000) ? ((s == EXECR && bus.funct7b5) ? 3'b001 : 3'b000) :
                     (bus.funct3 == 3'b010) ? 3'b101 :
                     (bus.funct3 == 3'b110) ? 3'b011 :
                     (bus.funct3 == 3'b111) ? 3'b010 : 3'b000;
  end
endmodule
